// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder slice.
// Holds the FSM state encoding, the DEPTH and WAIT_CYCLES defaults, the
// port-select constants and a small address-alignment helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEPTH_DEFAULT       = 1024;
  localparam int WAIT_CYCLES_DEFAULT = 2;

  // Wait-state counter width; covers WAIT_CYCLES in 0..15.
  localparam int CNT_W = 4;

  // Which requester owns the access in flight.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // A data access is word-only; any low address bit set rejects it.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: word storage behind the responder.
// Ports:
//   clk    - system clock
//   we     - write enable, write lands on the rising edge
//   waddr  - write word index
//   wdata  - write data
//   raddr  - read word index
//   rdata  - read data (combinational, so a same-edge write is not visible)
// Contents are intentionally not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read port; the caller registers the result.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: two-port (fetch + data) memory responder with a fixed
// number of wait states and one access in flight at a time.
// Ports:
//   clk, reset                     - clock, async active-high reset
//   if_req/if_addr                 - fetch request, held until if_ack
//   if_ack/if_rdata                - one-cycle fetch ack with data
//   d_req/d_we/d_addr/d_wdata      - data request, held until d_ack
//   d_ack/d_rdata/d_misalign       - one-cycle data ack with load data
//   busy                           - an access is being processed
// The array is read and written on the edge that raises the ack, so ack
// and rdata change together and a store ack returns the previous word.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_misalign,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               port_q, port_d;
  logic               we_q, we_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               mis_q, mis_d;

  logic               if_ack_q, if_ack_d;
  logic               d_ack_q, d_ack_d;
  logic               d_mis_q, d_mis_d;
  logic               busy_q, busy_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;

  logic               mem_we;
  logic [31:0]        mem_rdata;

  // Address bits outside the word index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2]};

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (idx_q),
    .rdata (mem_rdata)
  );

  // State register plus the latched request fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      port_q  <= PORT_IF;
      we_q    <= 1'b0;
      idx_q   <= {AW{1'b0}};
      wdata_q <= 32'h0000_0000;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state logic: arbitration (data wins), latching, wait countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (d_req) begin
          port_d  = PORT_D;
          we_d    = d_we;
          idx_d   = d_addr[AW+1:2];
          wdata_d = d_wdata;
          mis_d   = addr_misaligned(d_addr);
        end else if (if_req) begin
          port_d  = PORT_IF;
          we_d    = 1'b0;
          idx_d   = if_addr[AW+1:2];
          wdata_d = 32'h0000_0000;
          mis_d   = 1'b0;
        end else begin
          port_d  = port_q;
        end
        if (d_req || if_req) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output logic: in RESP, drive the array access and prepare the ack.
  always_comb begin
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    d_mis_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_we     = 1'b0;
    if (state_q == ST_RESP) begin
      if (port_q == PORT_D) begin
        d_ack_d = 1'b1;
        if (mis_q) begin
          d_mis_d   = 1'b1;
          d_rdata_d = 32'h0000_0000;
        end else begin
          d_rdata_d = mem_rdata;
          mem_we    = we_q;
        end
      end else begin
        if_ack_d   = 1'b1;
        if_rdata_d = mem_rdata;
      end
    end else begin
      mem_we = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      d_mis_q    <= 1'b0;
      busy_q     <= 1'b0;
      if_rdata_q <= 32'h0000_0000;
      d_rdata_q  <= 32'h0000_0000;
    end else begin
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      d_mis_q    <= d_mis_d;
      busy_q     <= busy_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_ack     = if_ack_q;
  assign if_rdata   = if_rdata_q;
  assign d_ack      = d_ack_q;
  assign d_rdata    = d_rdata_q;
  assign d_misalign = d_mis_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench. Instance 0 uses
// DEPTH=1024/WAIT_CYCLES=2, instance 1 uses DEPTH=64/WAIT_CYCLES=0.
// A word-array reference model predicts data; latency is predicted as
// WAIT_CYCLES+1 edges after the acceptance edge.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]       if_req, if_ack, d_req, d_we, d_ack, d_misalign, busy;
  logic [1:0][31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl_mem [2][1024];
  bit          mdl_ok  [2][1024];
  logic [31:0] last_if [2];
  logic [31:0] last_d  [2];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]), .d_misalign(d_misalign[0]), .busy(busy[0])
  );

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]), .d_misalign(d_misalign[1]), .busy(busy[1])
  );

  function automatic int wc_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 1024 : 64;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access on instance k; the DUT must be idle on entry.
  task automatic access(input int k, input bit is_d, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit scramble);
    int          idx;
    int          n;
    bit          got;
    bit          mis;
    logic [31:0] exp_rd;
    idx = int'(addr >> 2) & (depth_of(k) - 1);
    mis = is_d && (addr[1:0] != 2'b00);
    @(negedge clk);
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (scramble && n == 1) begin
        d_addr[k] = $urandom; d_wdata[k] = $urandom; d_we[k] = ~d_we[k];
        if_addr[k] = $urandom;
      end
      got = is_d ? d_ack[k] : if_ack[k];
    end
    d_req[k] = 1'b0;
    if_req[k] = 1'b0;
    check_eq(is_d ? "d_latency" : "if_latency", 32'(n), 32'(wc_of(k) + 2));
    exp_rd = mis ? 32'h0 : mdl_mem[k][idx];
    if (is_d) begin
      check_eq("d_misalign", {31'h0, d_misalign[k]}, {31'h0, mis});
      check_eq("if_ack_quiet", {31'h0, if_ack[k]}, 32'h0);
      if (mis || mdl_ok[k][idx]) check_eq("d_rdata", d_rdata[k], exp_rd);
      check_eq("if_rdata_kept", if_rdata[k], last_if[k]);
      last_d[k] = (mis || mdl_ok[k][idx]) ? exp_rd : d_rdata[k];
      if (we && !mis) begin
        mdl_mem[k][idx] = wdata;
        mdl_ok[k][idx]  = 1'b1;
      end
    end else begin
      check_eq("d_ack_quiet", {31'h0, d_ack[k]}, 32'h0);
      if (mdl_ok[k][idx]) check_eq("if_rdata", if_rdata[k], exp_rd);
      check_eq("d_rdata_kept", d_rdata[k], last_d[k]);
      last_if[k] = mdl_ok[k][idx] ? exp_rd : if_rdata[k];
    end
    @(posedge clk); #1;
    check_eq("ack_one_cycle", {31'h0, (d_ack[k] | if_ack[k])}, 32'h0);
    check_eq("d_rdata_hold", d_rdata[k], last_d[k]);
    check_eq("if_rdata_hold", if_rdata[k], last_if[k]);
  endtask

  task automatic check_reset_state(input int k);
    check_eq("rst_if_ack", {31'h0, if_ack[k]}, 32'h0);
    check_eq("rst_d_ack", {31'h0, d_ack[k]}, 32'h0);
    check_eq("rst_misalign", {31'h0, d_misalign[k]}, 32'h0);
    check_eq("rst_busy", {31'h0, busy[k]}, 32'h0);
    check_eq("rst_if_rdata", if_rdata[k], 32'h0);
    check_eq("rst_d_rdata", d_rdata[k], 32'h0);
  endtask

  initial begin
    int          n, dn, ifn, acks;
    logic [31:0] a, w;
    int          kind;

    if_req = 2'b00; d_req = 2'b00; d_we = 2'b00;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      last_if[k] = 32'h0; last_d[k] = 32'h0;
      for (int j = 0; j < 1024; j++) begin
        mdl_mem[k][j] = 32'h0; mdl_ok[k][j] = 1'b0;
      end
    end

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state(0);
    check_reset_state(1);
    @(negedge clk);
    reset = 1'b0;

    // Fill words 0..15 of instance 0 so later reads are predictable.
    for (int j = 0; j < 16; j++) access(0, 1'b1, 1'b1, 32'(j * 4), $urandom, 1'b0);

    // Store then load at 0x10.
    access(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check_eq("load_deadbeef", d_rdata[0], 32'hDEAD_BEEF);

    // Misaligned store leaves 0x10 untouched.
    access(0, 1'b1, 1'b1, 32'h13, 32'h5555_AAAA, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check_eq("misalign_no_write", d_rdata[0], 32'hDEAD_BEEF);

    // 0x1000 aliases word 0 with DEPTH=1024.
    access(0, 1'b1, 1'b1, 32'h1000, 32'h1234_5678, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("wrap_load", d_rdata[0], 32'h1234_5678);

    // Simultaneous requests: data first, fetch WAIT_CYCLES+2 later.
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10;
    if_req[0] = 1'b1; if_addr[0] = 32'h0;
    n = 0; dn = 0; ifn = 0;
    while (ifn == 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (d_ack[0] && dn == 0) begin
        dn = n;
        d_req[0] = 1'b0;
      end
      if (if_ack[0]) begin
        ifn = n;
        if_req[0] = 1'b0;
      end
      if (n == 1 || n == 2 || n == 3 || n == 5 || n == 6 || n == 7)
        check_eq("arb_busy", {31'h0, busy[0]}, 32'h1);
    end
    check_eq("arb_d_first", 32'(dn), 32'd4);
    check_eq("arb_if_after", 32'(ifn - dn), 32'd4);
    check_eq("arb_d_rdata", d_rdata[0], mdl_mem[0][4]);
    check_eq("arb_if_rdata", if_rdata[0], mdl_mem[0][0]);
    last_d[0] = mdl_mem[0][4];
    last_if[0] = mdl_mem[0][0];
    @(posedge clk); #1;

    // Randomized traffic with aliased high bits and late input changes.
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      a = (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'hFFFF_F000);
      w = $urandom;
      if (kind != 0 && $urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      access(0, kind != 0, kind == 2, a, w, $urandom_range(0, 1) == 1);
    end

    // Reset during WAIT of a store to 0x20 aborts it.
    w = mdl_mem[0][8];
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h20; d_wdata[0] = ~w;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("abort_busy_before", {31'h0, busy[0]}, 32'h1);
    reset = 1'b1;
    #1;
    check_reset_state(0);
    @(negedge clk);
    d_req[0] = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      last_if[k] = 32'h0; last_d[k] = 32'h0;
    end
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (d_ack[0]) acks++;
    end
    check_eq("abort_no_ack", 32'(acks), 32'd0);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check_eq("abort_no_commit", d_rdata[0], w);

    // Instance 1: fill words 0..3 through aliased addresses.
    for (int j = 0; j < 4; j++)
      access(1, 1'b1, 1'b1, 32'((64 + j) * 4) | ($urandom & 32'hFFFF_FE00), $urandom, 1'b0);
    access(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    access(1, 1'b0, 1'b0, 32'hC, 32'h0, 1'b1);

    // Held fetch request on WAIT_CYCLES=0: one ack every second cycle.
    @(negedge clk);
    if_req[1] = 1'b1; if_addr[1] = 32'h8;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      check_eq("tput_ack", {31'h0, if_ack[1]}, {31'h0, (c % 2 == 0)});
      if (c % 2 == 0) check_eq("tput_rdata", if_rdata[1], mdl_mem[1][2]);
    end
    if_req[1] = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
